// File: rtl/cic_5stage.sv
// -----------------------------------------------------------------------------
// cic_5stage -- five-integrator / five-comb CIC decimator (M = 1)
//
// The integrators run at the input rate. The combs run only on dec_clk
// strobes. The comb output is scaled down by S = 5*ceil(log2(R)), which gives
// unity DC gain for power-of-two R.
//
// Ports
//   clock     sole clock, rising edge
//   reset     asynchronous, active-high; clears every register
//   dec_clk   decimation strobe. The comb delays and dout update on clocks
//             where it is high.
//   dec_rate  decimation factor R (0 behaves as 1); only used to pick S
//   din       signed input sample, one per clock
//   dout      signed decimated output, registered
//
// Optional feature: define CIC_ROUND_EN to round half-up before the shift
// and saturate to the signed OUTPUT_WIDTH range. When it is undefined, dout
// is the plain truncated shift.
// -----------------------------------------------------------------------------
module cic_5stage #(
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 16,
  parameter int ACC_WIDTH    = INPUT_WIDTH + 40
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    dec_clk,
  input  logic [7:0]              dec_rate,
  input  logic [INPUT_WIDTH-1:0]  din,
  output logic [OUTPUT_WIDTH-1:0] dout
);

  localparam int STAGES = 5;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  // Integrator chain: every stage adds the previous stage's register.
  // This gives one clock of latency per stage, so five clocks in total.
  acc_t din_ext;
  acc_t integ_q [STAGES];
  acc_t integ_d [STAGES];

  // Comb chain. comb_c[0] is the last integrator. comb_c[k+1] is
  // comb_c[k] minus that stage's delay register.
  acc_t comb_dly_q [STAGES];
  acc_t comb_c     [STAGES+1];

  logic [5:0]              shift_s;
  logic [OUTPUT_WIDTH-1:0] dout_q, dout_d;

  // S = 5*ceil(log2(R)). ceil(log2(R)) is the bit length of R-1, and R=0
  // is folded onto R=1.
  function automatic logic [5:0] shift_of(input logic [7:0] r);
    logic [7:0] rm1;
    logic [5:0] lg;
    rm1 = (r == 8'd0) ? 8'd0 : r - 8'd1;
    lg  = '0;
    for (int i = 0; i < 8; i++)
      if (rm1[i]) lg = 6'(i + 1);
    return (lg << 2) + lg;
  endfunction

  assign shift_s = shift_of(dec_rate);
  assign din_ext = {{(ACC_WIDTH-INPUT_WIDTH){din[INPUT_WIDTH-1]}}, din};

  // Wrap-around is intended: with modulo arithmetic, the comb differences
  // are still exact even though the integrators overflow.
  always_comb begin
    integ_d[0] = integ_q[0] + din_ext;
    for (int k = 1; k < STAGES; k++)
      integ_d[k] = integ_q[k] + integ_q[k-1];
  end

  always_comb begin
    comb_c[0] = integ_q[STAGES-1];
    for (int k = 0; k < STAGES; k++)
      comb_c[k+1] = comb_c[k] - comb_dly_q[k];
  end

`ifdef CIC_ROUND_EN
  // Round half up, then saturate. The bias add is modulo ACC_WIDTH like the
  // rest of the datapath.
  localparam acc_t OUT_MAX = acc_t'({{(ACC_WIDTH-OUTPUT_WIDTH+1){1'b0}},
                                     {(OUTPUT_WIDTH-1){1'b1}}});
  localparam acc_t OUT_MIN = acc_t'({{(ACC_WIDTH-OUTPUT_WIDTH+1){1'b1}},
                                     {(OUTPUT_WIDTH-1){1'b0}}});
  acc_t rnd_bias, biased, shifted;

  always_comb begin
    rnd_bias = '0;
    if (shift_s != 6'd0) rnd_bias = acc_t'(1) << (shift_s - 6'd1);
    biased  = comb_c[STAGES] + rnd_bias;
    shifted = biased >>> shift_s;
    if (shifted > OUT_MAX)
      dout_d = OUT_MAX[OUTPUT_WIDTH-1:0];
    else if (shifted < OUT_MIN)
      dout_d = OUT_MIN[OUTPUT_WIDTH-1:0];
    else
      dout_d = shifted[OUTPUT_WIDTH-1:0];
  end
`else
  // Arithmetic shift, then keep the low OUTPUT_WIDTH bits.
  always_comb begin
    dout_d = OUTPUT_WIDTH'(comb_c[STAGES] >>> shift_s);
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k]    <= '0;
        comb_dly_q[k] <= '0;
      end
      dout_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++)
        integ_q[k] <= integ_d[k];
      // Strobe spacing is not checked. If dec_clk is held high, the combs
      // and dout update on every clock.
      if (dec_clk) begin
        for (int k = 0; k < STAGES; k++)
          comb_dly_q[k] <= comb_c[k];
        dout_q <= dout_d;
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_cic_5stage.sv
// -----------------------------------------------------------------------------
// tb_cic_5stage -- self-checking bench for cic_5stage (default parameters)
// DC vectors come from a table. Expected outputs go into a scoreboard queue
// when a strobe is driven, and are popped after the edge that loads dout.
// The ramp and mid-stream reset cases are written out by hand.
// -----------------------------------------------------------------------------
module tb_cic_5stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        dec_clk;
  logic [7:0]  dec_rate;
  logic [15:0] din;
  logic [15:0] dout;

  int checks = 0;
  int errors = 0;
  int sb[$];

  typedef struct {
    string name;
    int    rate;
    int    period;
    int    dval;
    int    expv;
    int    npulse;
    int    nsettle;
  } vec_t;

  vec_t vecs[7];

  cic_5stage dut (
    .clock    (clock),
    .reset    (reset),
    .dec_clk  (dec_clk),
    .dec_rate (dec_rate),
    .din      (din),
    .dout     (dout)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Hold reset for 5 clocks, check the cleared output, then release.
  task automatic do_reset();
    reset   = 1'b1;
    dec_clk = 1'b0;
    din     = '0;
    repeat (5) @(posedge clock);
    #1;
    check("reset_dout", $signed(dout), 0);
    reset = 1'b0;
  endtask

  // Constant input with a strobe every `period` clocks. Outputs after the
  // first nsettle strobes are compared through the scoreboard.
  task automatic run_dc(input string name, input int rate, input int period,
                        input int dval, input int expv, input int npulse,
                        input int nsettle);
    int pulses;
    int cnt;
    pulses   = 0;
    cnt      = 0;
    dec_rate = rate[7:0];
    din      = dval[15:0];
    while (pulses < npulse) begin
      dec_clk = (cnt == period - 1);
      if (dec_clk && pulses >= nsettle) sb.push_back(expv);
      @(posedge clock);
      #1;
      if (dec_clk) begin
        if (pulses >= nsettle) check(name, $signed(dout), sb.pop_front());
        pulses++;
      end
      cnt = (cnt == period - 1) ? 0 : cnt + 1;
    end
    dec_clk = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    dec_clk  = 1'b0;
    dec_rate = 8'd8;
    din      = '0;

    vecs[0] = '{"dc_r8_pos",   8,   8,  1000,  1000,   30, 20};
    vecs[1] = '{"dc_r8_neg",   8,   8, -1000, -1000,   30, 20};
    vecs[2] = '{"dc_r5",       5,   5,  1000,    95,   30, 20};
    vecs[3] = '{"dc_r0_as_1",  0,   1,  1000,  1000,   40, 20};
    vecs[4] = '{"dc_r4_neg",   4,   4,  -300,  -300,   30, 20};
`ifdef CIC_ROUND_EN
    vecs[5] = '{"dc_r255",   255, 255,  1000,   981,   26, 20};
`else
    vecs[5] = '{"dc_r255",   255, 255,  1000,   980,   26, 20};
`endif
    vecs[6] = '{"dc_r8_wrap",  8,   8, 32767, 32767, 1250, 20};

    for (int v = 0; v < 7; v++) begin
      do_reset();
      run_dc(vecs[v].name, vecs[v].rate, vecs[v].period, vecs[v].dval,
             vecs[v].expv, vecs[v].npulse, vecs[v].nsettle);
    end

    // Ramp with R=1 and the strobe held high: dout follows din six clocks
    // later. The queue starts with the five zero samples seen before the
    // ramp begins.
    do_reset();
    dec_rate = 8'd1;
    dec_clk  = 1'b1;
    for (int i = 0; i < 5; i++) sb.push_back(0);
    for (int j = 0; j < 40; j++) begin
      din = j[15:0];
      sb.push_back(j);
      @(posedge clock);
      #1;
      check("ramp_r1", $signed(dout), sb.pop_front());
    end
    sb.delete();
    dec_clk = 1'b0;

    // Mid-stream asynchronous reset, asserted between clock edges.
    do_reset();
    run_dc("pre_async_rst", 8, 8, 1000, 1000, 25, 20);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_dout", $signed(dout), 0);
    do_reset();
    run_dc("post_async_rst", 8, 8, 1000, 1000, 30, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
